// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser + debouncer front end for the button
// matrix. Produces debounced level, press/release pulses, long-press pulse
// and optional toggle latches.
// Optional build macro: KEY_AUTOREPEAT_EN -- key_hold re-pulses every
// REPEAT_CYCLES after the first long-press pulse while the key stays down.

module key_conditioner_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int HOLD_CYCLES     = 5000,
  parameter int REPEAT_CYCLES   = 1000,
  parameter bit LATCH_EN        = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic key_i,
  input  logic clr_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic latch_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1)
  begin : g_bad_cfg
    $error("key_conditioner: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          db_q, db_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   level_q, level_d;
  logic                   prev_q;
  logic                   hit_q, hit_d;
  logic                   latch_q, latch_d;
  logic                   s, sat;

  assign s   = sync_q[SYNC_STAGES-1];
  assign sat = (hold_q == HOLD_MAX);

  // Debounce: level follows s only after it differs for DEBOUNCE_CYCLES edges
  always_comb begin
    db_d    = db_q;
    level_d = level_q;
    if (s == level_q) begin
      db_d = '0;
    end else if (db_q == DB_LAST) begin
      level_d = s;
      db_d    = '0;
    end else begin
      db_d = db_q + 1'b1;
    end
  end

  // Hold count tracks next level so the press cycle already reads 1
  always_comb begin
    hold_d = '0;
    if (level_d) hold_d = sat ? hold_q : hold_q + 1'b1;
    hit_d  = level_d & sat;
  end

  assign press_o   = level_q & ~prev_q;
  assign release_o = ~level_q & prev_q;

  // Clear beats toggle; unmasked keys keep a flop stuck at 0
  always_comb begin
    latch_d = 1'b0;
    if (LATCH_EN) latch_d = clr_i ? 1'b0 : (press_o ? ~latch_q : latch_q);
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES);
  logic [RW-1:0] rep_q, rep_d;

  // Repeat phase runs only while the hold count sits saturated
  always_comb begin
    rep_d = '0;
    if (level_d && sat) rep_d = (rep_q == REP_MAX) ? RW'(1) : rep_q + 1'b1;
  end

  // Repeat counter state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rep_q <= '0;
    else        rep_q <= rep_d;
  end

  assign hold_o = sat & (~hit_q | (rep_q == REP_MAX));
`else
  assign hold_o = sat & ~hit_q;
`endif

  // Channel state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q  <= '0;
      db_q    <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      hold_q  <= '0;
      hit_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_i};
      db_q    <= db_d;
      level_q <= level_d;
      prev_q  <= level_q;
      hold_q  <= hold_d;
      hit_q   <= hit_d;
      latch_q <= latch_d;
    end
  end

  assign level_o = level_q;
  assign latch_o = latch_q;
endmodule

module key_conditioner #(
  parameter int                  NUM_KEYS        = 11,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 100,
  parameter int                  HOLD_CYCLES     = 5000,
  parameter int                  REPEAT_CYCLES   = 1000,
  parameter logic [NUM_KEYS-1:0] LATCH_MASK      = 11'b00000000011
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [NUM_KEYS-1:0] latch_clear,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold,
  output logic [NUM_KEYS-1:0] key_latch
);
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_conditioner_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .LATCH_EN       (LATCH_MASK[i])
    ) u_chan (
      .clk      (clk),
      .n_rst    (n_rst),
      .key_i    (keys[i]),
      .clr_i    (latch_clear[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .hold_o   (key_hold[i]),
      .latch_o  (key_latch[i])
    );
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus randomized key traffic,
// all checked each cycle against a cycle-level behavioural model.
module tb_key_conditioner;
  localparam int NK = 11, SS = 2, DB = 4, HC = 10, RC = 3;
  localparam logic [NK-1:0] LM = 11'h003;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [NK-1:0] keys = '0, latch_clear = '0;
  logic [NK-1:0] key_level, key_press, key_release, key_hold, key_latch;

  key_conditioner #(
    .NUM_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .LATCH_MASK(LM)
  ) dut (
    .clk(clk), .n_rst(n_rst), .keys(keys), .latch_clear(latch_clear),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_hold(key_hold), .key_latch(key_latch)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model: raw samples age through a queue, debounce is a run length of
  // disagreeing samples, hold is the plain number of cycles the key is down.
  logic [NK-1:0] hq[$];
  logic [NK-1:0] m_level, m_prev, m_latch;
  int m_run[NK];
  int m_hold[NK];
  int npress;

  task automatic model_reset();
    hq.delete();
    for (int k = 0; k < SS; k++) hq.push_back('0);
    m_level = '0; m_prev = '0; m_latch = '0;
    for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_hold[i] = 0; end
  endtask

  task automatic model_edge(input logic [NK-1:0] k, input logic [NK-1:0] c);
    logic [NK-1:0] s, pr;
    s  = hq[0];
    pr = m_level & ~m_prev;
    for (int i = 0; i < NK; i++)
      if (LM[i]) m_latch[i] = c[i] ? 1'b0 : (pr[i] ? ~m_latch[i] : m_latch[i]);
    m_prev = m_level;
    for (int i = 0; i < NK; i++) begin
      if (s[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin m_level[i] = s[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
      m_hold[i] = m_level[i] ? m_hold[i] + 1 : 0;
    end
    void'(hq.pop_front());
    hq.push_back(k);
  endtask

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NK-1:0] eh;
    for (int i = 0; i < NK; i++)
      eh[i] = m_level[i] && m_hold[i] >= HC &&
              (m_hold[i] == HC || (AR && ((m_hold[i] - HC) % RC == 0)));
    chk("level",   key_level,   m_level);
    chk("press",   key_press,   m_level & ~m_prev);
    chk("release", key_release, ~m_level & m_prev);
    chk("hold",    key_hold,    eh);
    chk("latch",   key_latch,   m_latch);
    npress += $countones(key_press);
  endtask

  task automatic step(input logic [NK-1:0] k, input logic [NK-1:0] c);
    keys = k; latch_clear = c;
    @(posedge clk);
    if (!n_rst) model_reset(); else model_edge(k, c);
    #1;
    check_all();
  endtask

  task automatic reset_pulse();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_level", key_level, '0);
    chk("rst_latch", key_latch, '0);
    step(keys, '0);
    n_rst = 1'b1;
  endtask

  initial begin
    logic [NK-1:0] k, c;
    int rate;
    npress = 0;
    model_reset();
    reset_pulse();

    // Clean press on key 2: level rises on the 6th edge after the change
    for (int n = 1; n <= 20; n++) begin
      step(11'h004, '0);
      if (n == 5) chk("lat_before", key_level, '0);
      if (n == 6) chk("lat_edge6", key_level, 11'h004);
    end
    for (int n = 0; n < 8; n++) step('0, '0);

    // Short glitches on key 3 are rejected
    npress = 0;
    for (int r = 0; r < 5; r++) begin
      for (int n = 0; n < 3; n++) step(11'h008, '0);
      for (int n = 0; n < 3; n++) step('0, '0);
    end
    for (int n = 0; n < 8; n++) step('0, '0);
    chk("glitch_level", key_level, '0);
    chk("glitch_press_cnt", NK'(npress), '0);

    // Key 0 toggled twice
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 8; n++) step(11'h001, '0);
      for (int n = 0; n < 8; n++) step('0, '0);
      chk("latch0_toggle", key_latch, (r == 0) ? 11'h001 : 11'h000);
    end

    // Key 1: clear coincident with press wins, next press sets the latch
    for (int n = 1; n <= 6; n++) step(11'h002, '0);
    chk("press1_now", key_press, 11'h002);
    step(11'h002, 11'h002);
    for (int n = 0; n < 8; n++) step('0, '0);
    chk("clear_wins", key_latch, '0);
    for (int n = 0; n < 8; n++) step(11'h002, '0);
    for (int n = 0; n < 8; n++) step('0, '0);
    chk("latch1_set", key_latch, 11'h002);

    // Key 5 long press; latch_clear on unmasked keys does nothing
    for (int n = 1; n <= 26; n++) begin
      step(11'h020, 11'h7FC);
      if (n == 15) chk("hold5_pulse", key_hold, 11'h020);
      if (n == 14 || n == 16) chk("hold5_quiet", key_hold, '0);
    end
    for (int n = 0; n < 10; n++) step('0, '0);

    // All keys held through a reset in the middle of debounce
    for (int n = 0; n < 4; n++) step(11'h7FF, 11'h002);
    reset_pulse();
    for (int n = 1; n <= 8; n++) begin
      step(11'h7FF, '0);
      if (n == 5) chk("rst_rel_lvl5", key_level, '0);
      if (n == 6) chk("rst_rel_lvl6", key_level, 11'h7FF);
      if (n == 6) chk("rst_rel_press", key_press, 11'h7FF);
      if (n == 7) chk("rst_rel_latch", key_latch, 11'h003);
    end
    for (int n = 0; n < 10; n++) step('0, '0);

    // Randomized traffic with varying toggle rates and occasional resets
    k = '0;
    for (int seg = 0; seg < 12; seg++) begin
      rate = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 10 : 40);
      if (seg == 7) reset_pulse();
      for (int n = 0; n < 300; n++) begin
        for (int i = 0; i < NK; i++) begin
          if ($urandom_range(rate - 1) == 0) k[i] = ~k[i];
          c[i] = ($urandom_range(15) == 0);
        end
        step(k, c);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
